// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_vr valid/ready pipeline: default sizes and
// the occupancy-counter width helper.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to count 0..depth stored words.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_vr_if.sv
// Producer/consumer handshake bundle for pipe_vr. The pipe sits on the slave
// modport; whatever drives and drains it uses the master modport.
interface pipe_vr_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

endinterface

// File: rtl/pipe_vr_stage.sv
// One valid/data register of pipe_vr. Data only loads when a valid word moves
// in, so a drained stage keeps its last payload.
module pipe_vr_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } pipe_stage_t;

    pipe_stage_t stage_reg;

    // Flush only drops the valid bit; the payload is left untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else if (flush) begin
            stage_reg.valid <= 1'b0;
        end else if (adv) begin
            stage_reg.valid <= prev_valid;
            if (prev_valid) begin
                stage_reg.data <= prev_data;
            end
        end
    end

    assign valid = stage_reg.valid;
    assign data  = stage_reg.data;

endmodule

// File: rtl/pipe_vr.sv
// N-stage valid/ready pipeline with bubble collapsing and synchronous flush.
// Define PIPE_VR_OCC_EN to add a registered occupancy output port.
module pipe_vr
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    pipe_vr_if.slave bus
`ifdef PIPE_VR_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_vr: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_width_check
        $error("pipe_vr: WIDTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_ready_int;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        // Unrolled ready chain: stage gi may advance when the consumer takes a
        // word or some stage from gi onwards is empty.
        assign adv[gi] = bus.out_ready || !(&v[DEPTH-1:gi]);

        if (gi == 0) begin : g_first
            pipe_vr_stage #(.WIDTH(WIDTH)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (bus.flush),
                .adv        (adv[gi]),
                .prev_valid (bus.in_valid),
                .prev_data  (bus.in_data),
                .valid      (v[gi]),
                .data       (d[gi])
            );
        end else begin : g_rest
            pipe_vr_stage #(.WIDTH(WIDTH)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (bus.flush),
                .adv        (adv[gi]),
                .prev_valid (v[gi-1]),
                .prev_data  (d[gi-1]),
                .valid      (v[gi]),
                .data       (d[gi])
            );
        end
    end

    assign in_ready_int  = adv[0] && !bus.flush;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];

`ifdef PIPE_VR_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    // Internal moves never change the word count; only the ends do.
    assign in_fire  = bus.in_valid && in_ready_int;
    assign out_fire = v[DEPTH-1] && bus.out_ready;

    always_comb begin
        occ_next = occ_reg;
        if (bus.flush) begin
            occ_next = '0;
        end else if (in_fire && !out_fire) begin
            occ_next = occ_reg + OCC_ONE;
        end else if (out_fire && !in_fire) begin
            occ_next = occ_reg - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign occupancy = occ_reg;

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) 32'(occ_reg) <= DEPTH);
`endif

endmodule

// File: tb/tb_pipe_vr.sv
// Randomised and directed stimulus for pipe_vr (WIDTH=8, DEPTH=3) checked by a
// scoreboard that models the pipe as a bounded FIFO with fixed fill latency.
module tb_pipe_vr;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_vr_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_VR_OCC_EN
    logic [1:0] occupancy;
`endif

    pipe_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef PIPE_VR_OCC_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: words currently held, with the edge each was accepted.
    // The oldest word has nothing ahead of it, so it reaches the output
    // DEPTH-1 edges after acceptance and then waits there for the consumer.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } exp_t;
    exp_t q[$];

    logic exp_ov;
    logic exp_ir;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (edge_cnt >= q[0].t + DEPTH - 1);
            exp_ir = !bus.flush && ((q.size() < DEPTH) || bus.out_ready);
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
`ifdef PIPE_VR_OCC_EN
            check("occupancy", 32'(occupancy), 32'(q.size()));
`endif
            if (exp_ov) begin
                check("out_data", 32'(bus.out_data), 32'(q[0].d));
                if (bus.out_ready) begin
                    $display("xfer out 0x%02h at edge %0d", q[0].d, edge_cnt + 1);
                    void'(q.pop_front());
                end
            end
            if (bus.flush) begin
                q.delete();
            end else if (bus.in_valid && exp_ir) begin
                q.push_back('{d: bus.in_data, t: edge_cnt + 1});
            end
        end
    end

    logic [WIDTH-1:0] src[$];

    // Drive one cycle; acc reports whether the word was taken at the edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl, output logic acc);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
        acc = iv && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic pump(input int ncyc, input logic ordy);
        logic acc;
        for (int c = 0; c < ncyc; c++) begin
            if (src.size() > 0) step(1'b1, src[0], ordy, 1'b0, acc);
            else                step(1'b0, '0, ordy, 1'b0, acc);
            if (acc) void'(src.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic holding;
        logic iv;
        logic fl;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;

        // Reset over three edges, then check the reset payload.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_data", 32'(bus.out_data), 32'h0);
        @(posedge clk);
        #1;

        // Back-to-back streaming.
        for (int i = 1; i <= 16; i++) src.push_back(WIDTH'(i));
        pump(16, 1'b1);
        check("stream_all_accepted", 32'(src.size()), 32'd0);
        pump(4, 1'b1);

        // Backpressure: only DEPTH words fit, the fourth stays with the producer.
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        pump(6, 1'b0);
        check("bp_words_left", 32'(src.size()), 32'd1);
        if (src.size() > 0) check("bp_held_word", 32'(src[0]), 32'hA3);
        pump(8, 1'b1);

        // Bubble collapse with the consumer stalled.
        step(1'b1, 8'hB0, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b1, 8'hB1, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("bubble_in_ready", 32'(bus.in_ready), 32'd0 + 32'(q.size() < DEPTH));
        pump(5, 1'b1);

        // Full pipe passing straight through.
        src = '{8'hC0, 8'hC1, 8'hC2};
        pump(3, 1'b0);
        for (int i = 0; i < 8; i++) src.push_back(8'hD0 + WIDTH'(i));
        pump(8, 1'b1);
        check("passthru_all_accepted", 32'(src.size()), 32'd0);
        pump(4, 1'b1);

        // Flush with two words held while the producer offers 0x55.
        src = '{8'hE0, 8'hE1};
        pump(2, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, acc);
        check("flush_rejects_input", 32'(acc), 32'd0);
        check("flush_clears_out_valid", 32'(bus.out_valid), 32'd0);
        pump(4, 1'b1);

        // Random traffic with occasional flushes; producer holds until taken.
        src.delete();
        holding = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (src.size() == 0) src.push_back(WIDTH'($urandom));
            iv = holding ? 1'b1 : 1'b0 + 1'($urandom_range(0, 2) != 0);
            fl = 1'($urandom_range(0, 39) == 0);
            step(iv, src[0], 1'($urandom_range(0, 3) != 0), fl, acc);
            if (acc) void'(src.pop_front());
            holding = iv && !acc;
        end
        src.delete();
        pump(6, 1'b1);
        check("final_drain", 32'(q.size()), 32'd0);

        // Asynchronous reset mid-stream clears the output without an edge.
        src = '{8'hF0, 8'hF1, 8'hF2};
        pump(3, 1'b0);
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1 check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pump(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_vr.md
Name: pipe_vr

Overview:
- Parametrised N-stage data pipeline with a full valid/ready handshake.
- Successor to the 2-stage valid-only pipe. Adds configurable width and depth, downstream backpressure, bubble collapsing and a synchronous flush.
- Sits between producer and consumer datapath blocks wherever registered latency with lossless stall is needed.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1). DEPTH=0 raises an elaboration-time $error.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  producer has data.
- in_ready  output  1  pipe accepts data this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  stage DEPTH-1 holds data.
- out_ready  input  1  consumer accepts data.
- out_data  output  WIDTH  stage DEPTH-1 data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all stage valids v[0..DEPTH-1]=0 and all stage data d[]=0. So out_valid=0 and out_data=0. in_ready=1 once rst deasserts, provided flush is low.
- Reset mid-operation: all in-flight data is discarded immediately, with no wait for a clock edge.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - in_valid is independent of in_ready; the producer must hold data stable until the transfer.
- Stage-ready chain, combinational:
  - adv[DEPTH-1] = out_ready || !v[DEPTH-1].
  - adv[i] = adv[i+1] || !v[i].
  - in_ready = adv[0] && !flush.
- Per-stage update for stage i>0:
  - If adv[i], then v[i] <= v[i-1] and d[i] <= d[i-1], but d[i] loads only when v[i-1]=1.
  - Otherwise the stage holds.
- Stage 0 update:
  - If adv[0], then v[0] <= in_valid && !flush and d[0] <= in_data, but d[0] loads only when in_valid=1.
- Data registers load only on valid moves. out_data therefore holds its last value while out_valid=0. The bench must not check out_data when out_valid=0.
- Latency: with out_ready held at 1, data accepted at edge k appears at out_valid/out_data after edge k+DEPTH-1. That is DEPTH cycles of register delay, counting stage 0.
- Throughput: one word per cycle sustained when out_ready=1.
- Bubble collapse: an empty stage always accepts from its predecessor, even while downstream is stalled. A stalled pipe therefore fills to DEPTH words before in_ready drops.
- Full with out_ready=1: all stages advance in the same cycle. in_ready=1 and simultaneous in/out is lossless.
- Full with out_ready=0: in_ready=0 and all stages hold.
- Flush:
  - On an edge with flush=1, all v[] <= 0 and the input is not accepted (in_ready=0 during flush).
  - Flush has priority over any in/out transfer. An out transfer visible in the flush cycle still counts as consumed by the consumer.
  - d[] is unchanged by flush.
- Ordering: strict FIFO. No word is duplicated or dropped except by flush or rst.

Optional Feature:
- Macro: PIPE_VR_OCC_EN.
- Defined: adds output port occupancy [$clog2(DEPTH+1)-1:0], registered.
  - Equals the count of set v[] bits after each edge.
  - Reset 0, cleared by flush.
  - Must never exceed DEPTH.
- Undefined: port and counter logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Localparam function for the occupancy width, clog2(DEPTH+1).
  - Typedef pipe_stage_t {logic valid; logic [WIDTH-1:0] data}, parametrised via a per-instance struct in the module if the package cannot carry WIDTH.
- Natural sub-module: pipe_vr_stage. This is one valid/data register with inputs prev_valid, prev_data, adv and flush, and outputs valid and data. pipe_vr instantiates DEPTH of them in a generate loop and builds the adv chain.

Test Plan:
- Reset: hold rst=1 over 3 edges, then release. Required: out_valid=0, out_data=0, in_ready=1, occupancy=0. Asserting rst between edges mid-stream clears out_valid with no clock edge.
- Streaming, WIDTH=8, DEPTH=3, out_ready=1: drive in_data 0x01..0x10 back-to-back. Required: 0x01 appears on out_data after the 3rd edge, then one word per cycle in order, with in_ready=1 throughout.
- Backpressure: out_ready=0 and drive 0xA0,0xA1,0xA2,0xA3. Required: in_ready drops after 3 accepted words (occupancy=3) and 0xA3 is held by the producer. Raising out_ready then yields 0xA0..0xA3 in order with no loss.
- Bubble collapse: in_valid pattern 1,0,1,0 with out_ready=0. Required: both words packed into stages 2 and 1 (occupancy=2) and in_ready=1 still.
- Full pass-through: pipe full and out_ready=1 with in_valid=1 every cycle. Required: in_ready=1, occupancy stays at DEPTH, one in and one out per edge.
- Flush: mid-stream with 2 words held, flush=1 for one edge while in_valid=1 with 0x55. Required: in_ready=0, then out_valid=0 and occupancy=0 after the edge, and 0x55 never appears on the output.
